shift_add_mult_ctrl: RTL

FSM sequencer for the N-bit shift-add multiplier datapath. Drives the 2-bit ctrl codes of three shift_register instances (M multiplicand, Q multiplier, A accumulator), the carry flop and the accumulator source mux. Wraps the whole operation in a start/busy and out_valid/out_ready handshake. Sits between the requesting logic and the datapath and contains no arithmetic itself.

---
 rtl/mult_pkg.sv | 25 ++
 rtl/mult_iter_counter.sv | 28 ++
 rtl/shift_add_mult_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types for the shift-add multiplier: shift_register ctrl codes,
// sequencer states and the A-register source select.
package mult_pkg;

  typedef enum logic [1:0] {
    SR_HOLD = 2'b00,
    SR_SHR  = 2'b01,
    SR_SHL  = 2'b10,
    SR_LOAD = 2'b11
  } sr_ctrl_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADD,
    SHIFT,
    DONE
  } mult_state_e;

  typedef enum logic {
    A_SRC_ZERO = 1'b0,
    A_SRC_SUM  = 1'b1
  } a_src_e;

endpackage

// File: rtl/mult_iter_counter.sv
// Shift-round counter for the multiplier sequencer; last flags the final
// (N-th) shift so the FSM can leave the ADD/SHIFT loop.
module mult_iter_counter #(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] iter,
  output logic             last
);

  // clear takes priority so an abort during SHIFT still lands on zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter <= '0;
    end else if (clear) begin
      iter <= '0;
    end else if (inc) begin
      iter <= iter + 1'b1;
    end
  end

  assign last = (iter == CNT_W'(N - 1));

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// FSM sequencer for the N-bit shift-add multiplier datapath: drives the
// M/Q/A shift_register ctrl codes, carry flop and A source mux.
module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter  int N     = 8,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             q0,
  input  logic             out_ready,
  output logic [1:0]       m_ctrl,
  output logic [1:0]       q_ctrl,
  output logic [1:0]       a_ctrl,
  output logic             a_src,
  output logic             c_ld,
  output logic             c_clr,
  output logic             busy,
  output logic             out_valid,
  output logic [CNT_W-1:0] iter
);

  mult_state_e state;
  logic        cnt_clear;
  logic        cnt_inc;
  logic        cnt_last;

  assign cnt_clear = (state == LOAD) || (abort && (state != IDLE));
  assign cnt_inc   = (state == SHIFT);

  mult_iter_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .iter  (iter),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:  if (start && !abort) state <= LOAD;
        LOAD:  state <= abort ? IDLE : ADD;
        ADD:   state <= abort ? IDLE : SHIFT;
        SHIFT: begin
          if (abort)         state <= IDLE;
          else if (cnt_last) state <= DONE;
          else               state <= ADD;
        end
        DONE:  if (abort || out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ADD must see q0 of the current Q contents, so outputs decode from the
  // registered state rather than being pre-registered a cycle early
  always_comb begin
    m_ctrl    = SR_HOLD;
    q_ctrl    = SR_HOLD;
    a_ctrl    = SR_HOLD;
    a_src     = A_SRC_ZERO;
    c_ld      = 1'b0;
    c_clr     = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      LOAD: begin
        m_ctrl = SR_LOAD;
        q_ctrl = SR_LOAD;
        a_ctrl = SR_LOAD;
        c_clr  = 1'b1;
        busy   = 1'b1;
      end
      ADD: begin
        busy = 1'b1;
        if (q0) begin
          a_ctrl = SR_LOAD;
          a_src  = A_SRC_SUM;
          c_ld   = 1'b1;
        end else begin
          c_clr = 1'b1;
        end
      end
      SHIFT: begin
        a_ctrl = SR_SHR;
        q_ctrl = SR_SHR;
        busy   = 1'b1;
      end
      DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

endmodule
